// File: rtl/byte_pack_ctrl.sv
// byte_pack_ctrl: sequences an external 32-bit byte shift register so that a
// byte stream is packed MSB-first into 32-bit words, then offers each word
// downstream and tags it with a 9-bit word address.
//
// Handshake semantics (both ports): a transfer happens on exactly the cycles
// where valid && ready are both high at the rising clock edge. Neither side
// may make valid depend on ready. in_valid may drop at any time. word_valid,
// once high, stays high with stable data until the word is taken.
module byte_pack_ctrl #(
    parameter logic [8:0] ADDR_BASE = 9'd0,
    parameter logic [8:0] JMP_ADDR  = 9'd48
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       sr_reset,
    output logic       sr_write,
    output logic       sr_shift,
    output logic [7:0] sr_data,
    output logic       word_valid,
    input  logic       word_ready,
    output logic [8:0] word_addr,
    input  logic       jmp,
    output logic [1:0] byte_cnt,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        FULL  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;
    logic   clear_strobe;
    logic   byte_take;
    logic   word_take;

    assign byte_take = (state == LOAD) && in_valid;
    assign word_take = (state == FULL) && word_ready;

    // Next-state decode; the fourth byte of a word goes straight to FULL
    // because no shift follows it.
    always_comb begin
        next_state = state;
        case (state)
            CLEAR: next_state = LOAD;
            LOAD:  if (in_valid) next_state = (byte_cnt == 2'd3) ? FULL : SHIFT;
            SHIFT: next_state = LOAD;
            FULL:  if (word_ready) next_state = LOAD;
            default: next_state = CLEAR;
        endcase
    end

    // State, byte counter, address pointer and the state-decoded outputs,
    // registered off the next state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CLEAR;
            byte_cnt     <= 2'd0;
            word_addr    <= ADDR_BASE;
            in_ready     <= 1'b0;
            word_valid   <= 1'b0;
            sr_shift     <= 1'b0;
            clear_strobe <= 1'b1;
        end else begin
            state        <= next_state;
            in_ready     <= (next_state == LOAD);
            word_valid   <= (next_state == FULL);
            sr_shift     <= (next_state == SHIFT);
            clear_strobe <= (next_state == CLEAR);

            if (state == CLEAR || word_take) begin
                byte_cnt <= 2'd0;
            end else if (byte_take && byte_cnt != 2'd3) begin
                byte_cnt <= byte_cnt + 2'd1;
            end

            // A jump wins over the handshake increment; the word is still taken.
            if (jmp) begin
                word_addr <= JMP_ADDR;
            end else if (word_take) begin
                word_addr <= word_addr + 9'd1;
            end
        end
    end

    // Write and the handshake clear follow the live inputs so a byte or word
    // moves in the same cycle it is offered.
    assign sr_write  = byte_take;
    assign sr_reset  = clear_strobe | word_take;
    assign sr_data   = in_data;
    assign fsm_state = state;

endmodule
